// File: rtl/q_pkg.sv
// Shared types and FSM encoding for the Q-learning step controller.
`timescale 1ns/1ps
package q_pkg;

  localparam int N_STATES = 37;
  localparam int N_ACT    = 4;

  typedef logic [5:0]         state_t;
  typedef logic [1:0]         action_t;
  typedef logic signed [31:0] qval_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_CUR  = 3'd1;
  localparam logic [2:0] ST_SELECT  = 3'd2;
  localparam logic [2:0] ST_ENV     = 3'd3;
  localparam logic [2:0] ST_RD_NXT  = 3'd4;
  localparam logic [2:0] ST_UPDATE  = 3'd5;
  localparam logic [2:0] ST_ADVANCE = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_CUR  = ST_RD_CUR,
    SELECT  = ST_SELECT,
    ENV     = ST_ENV,
    RD_NXT  = ST_RD_NXT,
    UPDATE  = ST_UPDATE,
    ADVANCE = ST_ADVANCE,
    DONE    = ST_DONE
  } fsm_t;

endpackage

// File: rtl/q_argmax4.sv
// Sequential signed max/argmax over a stream of Q values; strict '>' keeps the
// lowest index on ties.
`timescale 1ns/1ps
module q_argmax4
  import q_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    first,
  input  action_t idx,
  input  qval_t   data,
  output action_t best_idx,
  output qval_t   nxt_val
);

  qval_t   best_val_q, best_val_d;
  action_t best_idx_q, best_idx_d;
  logic    take;

  always_comb begin
    take       = en && (first || (data > best_val_q));
    best_val_d = take ? data : best_val_q;
    best_idx_d = take ? idx  : best_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  // The combinational next value lets the caller latch the final max on the
  // same edge that folds in the last entry.
  assign best_idx = best_idx_q;
  assign nxt_val  = best_val_d;

endmodule

// File: rtl/q_step_ctrl.sv
// Episode/step sequencer for Q-learning: reads Q rows, picks an action,
// talks to the maze environment and hands operands to the Q-update unit.
`timescale 1ns/1ps
module q_step_ctrl #(
  parameter int N_STATES    = 37,
  parameter int N_ACT       = 4,
  parameter int START_STATE = 0,
  parameter int GOAL_STATE  = 36,
  parameter int EPS_THRESH  = 26,
  parameter int MAX_STEPS   = 255,
  parameter int N_EPISODES  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        run_done,
  output logic [5:0]  rd_state,
  output logic [1:0]  rd_action,
  input  logic [31:0] rd_data,
  output logic        env_req,
  output logic [5:0]  env_state,
  output logic [1:0]  env_action,
  input  logic        env_ack,
  input  logic [5:0]  env_next,
  input  logic [3:0]  env_reward,
  output logic [5:0]  maze_state,
  output logic [1:0]  action,
  output logic [31:0] max_Q,
  input  logic        upd_done,
  output logic [3:0]  reward,
  output logic        upd_go,
  output logic [7:0]  episode,
  output logic [7:0]  steps
);

  import q_pkg::*;

  fsm_t        state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  state_t      maze_state_q, maze_state_d;
  state_t      rd_state_q, rd_state_d;
  state_t      env_next_q, env_next_d;
  action_t     action_q, action_d;
  action_t     rd_action_q, rd_action_d;
  qval_t       max_q_q, max_q_d;
  logic [3:0]  reward_q, reward_d;
  logic [7:0]  episode_q, episode_d;
  logic [7:0]  steps_q, steps_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic        rd_phase, is_goal, lfsr_fb;
  logic        am_en, am_first;
  action_t     am_idx, am_best_idx;
  qval_t       am_nxt_val;

  // Out-of-range successors end the episode exactly like the goal.
  assign is_goal  = (32'(env_next_q) == 32'(GOAL_STATE)) || (32'(env_next_q) >= 32'(N_STATES));
  assign rd_phase = (state_q == RD_CUR) || (state_q == RD_NXT);
  assign am_en    = rd_phase && (cnt_q != 3'd0);
  assign am_first = (cnt_q == 3'd1);
  assign am_idx   = action_t'(cnt_q - 3'd1);
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  q_argmax4 u_argmax (
    .clk      (clk),
    .rst_n    (rst),
    .en       (am_en),
    .first    (am_first),
    .idx      (am_idx),
    .data     (qval_t'(rd_data)),
    .best_idx (am_best_idx),
    .nxt_val  (am_nxt_val)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    maze_state_d = maze_state_q;
    rd_state_d   = rd_state_q;
    env_next_d   = env_next_q;
    action_d     = action_q;
    rd_action_d  = rd_action_q;
    max_q_d      = max_q_q;
    reward_d     = reward_q;
    episode_d    = episode_q;
    steps_d      = steps_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_fb};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RD_CUR;
          maze_state_d = state_t'(START_STATE);
          rd_state_d   = state_t'(START_STATE);
          rd_action_d  = '0;
          cnt_d        = '0;
          episode_d    = '0;
          steps_d      = '0;
        end
      end
      RD_CUR, RD_NXT: begin
        // Address for entry k is out during cnt k; its data arrives at cnt k+1.
        cnt_d = cnt_q + 3'd1;
        if (rd_action_q != action_t'(N_ACT - 1))
          rd_action_d = rd_action_q + 2'd1;
        if (cnt_q == 3'(N_ACT)) begin
          cnt_d = '0;
          if (state_q == RD_CUR) begin
            state_d = SELECT;
          end else begin
            state_d = UPDATE;
            max_q_d = is_goal ? '0 : am_nxt_val;
          end
        end
      end
      SELECT: begin
        action_d = (32'(lfsr_q[7:0]) < 32'(EPS_THRESH)) ? lfsr_q[9:8] : am_best_idx;
        state_d  = ENV;
      end
      ENV: begin
        if (env_ack) begin
          env_next_d  = env_next;
          reward_d    = env_reward;
          rd_state_d  = env_next;
          rd_action_d = '0;
          cnt_d       = '0;
          state_d     = RD_NXT;
        end
      end
      UPDATE: begin
        if (upd_done) state_d = ADVANCE;
        else          cnt_d   = 3'd1;
      end
      ADVANCE: begin
        if (is_goal || (steps_q == 8'(MAX_STEPS - 1))) begin
          episode_d    = episode_q + 8'd1;
          steps_d      = '0;
          maze_state_d = state_t'(START_STATE);
        end else begin
          steps_d      = steps_q + 8'd1;
          maze_state_d = env_next_q;
        end
        rd_state_d  = maze_state_d;
        rd_action_d = '0;
        cnt_d       = '0;
        state_d     = (episode_d == 8'(N_EPISODES)) ? DONE : RD_CUR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      maze_state_q <= state_t'(START_STATE);
      rd_state_q   <= '0;
      env_next_q   <= '0;
      action_q     <= '0;
      rd_action_q  <= '0;
      max_q_q      <= '0;
      reward_q     <= '0;
      episode_q    <= '0;
      steps_q      <= '0;
      lfsr_q       <= 16'hACE1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      maze_state_q <= maze_state_d;
      rd_state_q   <= rd_state_d;
      env_next_q   <= env_next_d;
      action_q     <= action_d;
      rd_action_q  <= rd_action_d;
      max_q_q      <= max_q_d;
      reward_q     <= reward_d;
      episode_q    <= episode_d;
      steps_q      <= steps_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign run_done   = (state_q == DONE);
  assign rd_state   = rd_state_q;
  assign rd_action  = rd_action_q;
  assign env_req    = (state_q == ENV);
  assign env_state  = maze_state_q;
  assign env_action = action_q;
  assign maze_state = maze_state_q;
  assign action     = action_q;
  assign max_Q      = max_q_q;
  assign reward     = reward_q;
  assign upd_go     = (state_q == UPDATE) && (cnt_q == 3'd0);
  assign episode    = episode_q;
  assign steps      = steps_q;

endmodule

// File: tb/tb_q_step_ctrl.sv
// Directed bench for q_step_ctrl: Q-table, maze and update-unit models plus
// a vector table for single steps and hand sequences for multi-cycle cases.
`timescale 1ns/1ps
module tb_q_step_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, run_done;
  logic [5:0]  rd_state;
  logic [1:0]  rd_action;
  logic [31:0] rd_data;
  logic        env_req, env_ack;
  logic [5:0]  env_state, env_next;
  logic [1:0]  env_action;
  logic [3:0]  env_reward;
  logic [5:0]  maze_state;
  logic [1:0]  action;
  logic [31:0] max_Q;
  logic [3:0]  reward;
  logic        upd_go, upd_done;
  logic [7:0]  episode, steps;

  always #5 clk = ~clk;

  q_step_ctrl #(
    .N_STATES(37), .N_ACT(4), .START_STATE(0), .GOAL_STATE(36),
    .EPS_THRESH(0), .MAX_STEPS(255), .N_EPISODES(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .run_done(run_done),
    .rd_state(rd_state), .rd_action(rd_action), .rd_data(rd_data),
    .env_req(env_req), .env_state(env_state), .env_action(env_action),
    .env_ack(env_ack), .env_next(env_next), .env_reward(env_reward),
    .maze_state(maze_state), .action(action), .max_Q(max_Q), .reward(reward),
    .upd_go(upd_go), .upd_done(upd_done), .episode(episode), .steps(steps)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s = %0d", name, actual);
    end
  endtask

  // Q-table model: registered read, data valid the cycle after the address.
  logic signed [31:0] qmem [64][4];
  logic [5:0] a_s;
  logic [1:0] a_a;
  initial begin
    rd_data = '0;
    forever begin
      @(negedge clk);
      a_s = rd_state;
      a_a = rd_action;
      @(posedge clk); #1;
      rd_data = qmem[a_s][a_a];
    end
  end

  // Maze model: mode 0 always returns env_fixed, mode 1 goes 0 -> 5 -> 36.
  int         env_dly = 0, env_mode = 0, env_cnt = 0, req_len = 0, act_viol = 0;
  logic [5:0] env_fixed = 6'd7;
  logic [3:0] env_rew = 4'd0;
  logic [1:0] act_seen = 2'd0;
  initial begin
    env_ack = 0; env_next = 0; env_reward = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst || env_ack) begin
        env_ack = 0;
        env_cnt = 0;
      end else if (env_req) begin
        if (env_cnt == 0) act_seen = env_action;
        else if (env_action !== act_seen) act_viol++;
        env_cnt++;
        if (env_cnt > env_dly) begin
          env_ack    = 1;
          req_len    = env_cnt;
          env_next   = (env_mode == 1) ? ((env_state == 6'd0) ? 6'd5 : 6'd36) : env_fixed;
          env_reward = env_rew;
        end
      end
    end
  end

  // Update-unit model: records operands at upd_go, answers after upd_dly cycles.
  int                 upd_cnt = 0, upd_dly = 0, upd_wait = 0, upd_viol = 0;
  bit                 upd_pend = 0;
  logic [1:0]         u_act;
  logic signed [31:0] u_maxq;
  logic [3:0]         u_rew;
  logic [5:0]         u_state;
  initial begin
    upd_done = 0;
    forever begin
      @(posedge clk); #1;
      upd_done = 0;
      if (!rst) begin
        upd_pend = 0;
      end else begin
        if (upd_go) begin
          upd_cnt++;
          upd_pend = 1;
          upd_wait = 0;
          u_act = action; u_maxq = max_Q; u_rew = reward; u_state = maze_state;
        end else if (upd_pend) begin
          if (action !== u_act || max_Q !== u_maxq || reward !== u_rew || maze_state !== u_state)
            upd_viol++;
        end
        if (upd_pend) begin
          if (upd_wait >= upd_dly) begin
            upd_done = 1;
            upd_pend = 0;
          end else begin
            upd_wait++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 0; start = 0;
    repeat (3) tick();
    rst = 1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic clear_mem();
    for (int s = 0; s < 64; s++)
      for (int a = 0; a < 4; a++) qmem[s][a] = '0;
  endtask

  task automatic wait_req(output int n, input int limit);
    n = 0;
    while (!env_req && n < limit) begin tick(); n++; end
    chk("env_req_seen", env_req, 1);
  endtask

  task automatic wait_upd(input int n, input int limit);
    int k = 0;
    while (upd_cnt < n && k < limit) begin tick(); k++; end
    chk("upd_go_seen", longint'(upd_cnt >= n), 1);
  endtask

  typedef struct {
    int qc0, qc1, qc2, qc3;
    int nxt;
    int qn0, qn1, qn2, qn3;
    int rew, act, maxq, maze, stp, ep;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    rst = 0; start = 0;
    clear_mem();

    vecs[0] = '{-5, 7, 7, 3,            7,  1, 2, 3, 4,                       10, 1, 4,          7, 1, 0};
    vecs[1] = '{1, 2, 3, 4,             7,  -10, -3, -7, -20,                 3,  3, -3,         7, 1, 0};
    vecs[2] = '{-1, -2, -3, -4,         7,  0, 0, 0, 0,                       1,  0, 0,          7, 1, 0};
    vecs[3] = '{0, 0, 0, 0,             36, 9, 9, 9, 9,                       10, 0, 0,          0, 0, 1};
    vecs[4] = '{-2147483647-1, 2147483647, 5, 5,
                                        7,  2147483647, -1, 0, -2147483647-1, 5,  1, 2147483647, 7, 1, 0};
    vecs[5] = '{-100, -50, -50, -200,   50, 100, 100, 100, 100,               15, 1, 0,          0, 0, 1};

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_env_req", env_req, 0);
    chk("rst_upd_go", upd_go, 0);
    chk("rst_episode", episode, 0);
    chk("rst_steps", steps, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      clear_mem();
      qmem[0][0] = vecs[v].qc0; qmem[0][1] = vecs[v].qc1;
      qmem[0][2] = vecs[v].qc2; qmem[0][3] = vecs[v].qc3;
      qmem[vecs[v].nxt][0] = vecs[v].qn0; qmem[vecs[v].nxt][1] = vecs[v].qn1;
      qmem[vecs[v].nxt][2] = vecs[v].qn2; qmem[vecs[v].nxt][3] = vecs[v].qn3;
      env_mode = 0; env_fixed = 6'(vecs[v].nxt); env_rew = 4'(vecs[v].rew);
      env_dly = 0; upd_dly = 0; upd_cnt = 0;
      $display("vector %0d: next=%0d reward=%0d", v, vecs[v].nxt, vecs[v].rew);
      pulse_start();
      chk("vec_busy", busy, 1);
      wait_req(n, 50);
      chk("vec_req_latency", n, 6);
      wait_upd(1, 60);
      chk("vec_action", u_act, vecs[v].act);
      chk("vec_max_Q", u_maxq, vecs[v].maxq);
      chk("vec_reward", u_rew, vecs[v].rew);
      chk("vec_upd_state", u_state, 0);
      wait_req(n, 50);
      chk("vec_maze_after", maze_state, vecs[v].maze);
      chk("vec_steps_after", steps, vecs[v].stp);
      chk("vec_episode_after", episode, vecs[v].ep);
    end

    // Delayed acknowledge: request held for the whole wait, single update.
    do_reset();
    clear_mem();
    qmem[0][3] = 4;
    env_mode = 0; env_fixed = 6'd7; env_rew = 4'd2;
    env_dly = 20; upd_dly = 0; upd_cnt = 0; act_viol = 0;
    pulse_start();
    wait_upd(1, 100);
    chk("hs_req_len", req_len, 21);
    chk("hs_action_stable_viol", act_viol, 0);
    chk("hs_action", u_act, 3);
    repeat (10) tick();
    chk("hs_single_upd", upd_cnt, 1);

    // Step cap: the maze never reaches the goal.
    do_reset();
    clear_mem();
    env_mode = 0; env_fixed = 6'd1; env_rew = 4'd0;
    env_dly = 0; upd_dly = 0; upd_cnt = 0;
    pulse_start();
    wait_upd(254, 6000);
    wait_req(n, 50);
    chk("cap_steps_254", steps, 254);
    chk("cap_episode_0", episode, 0);
    wait_upd(255, 100);
    wait_req(n, 50);
    chk("cap_steps_wrap", steps, 0);
    chk("cap_episode_1", episode, 1);
    chk("cap_maze_start", maze_state, 0);

    // Asynchronous reset while the update unit stalls.
    do_reset();
    clear_mem();
    qmem[0][2] = 9;
    qmem[7][0] = 1; qmem[7][1] = 5; qmem[7][2] = 2; qmem[7][3] = 3;
    env_mode = 0; env_fixed = 6'd7; env_rew = 4'd10;
    env_dly = 0; upd_dly = 100000; upd_cnt = 0; upd_viol = 0;
    pulse_start();
    wait_upd(1, 60);
    repeat (2) tick();
    chk("mid_upd_max_Q", max_Q, 5);
    chk("mid_upd_action", action, 2);
    chk("mid_upd_hold_viol", upd_viol, 0);
    #3;
    rst = 0;
    #1;
    chk("arst_env_req", env_req, 0);
    chk("arst_upd_go", upd_go, 0);
    chk("arst_busy", busy, 0);
    chk("arst_run_done", run_done, 0);
    chk("arst_episode", episode, 0);
    chk("arst_steps", steps, 0);
    chk("arst_maze", maze_state, 0);
    chk("arst_action", action, 0);
    chk("arst_max_Q", max_Q, 0);
    chk("arst_reward", reward, 0);
    chk("arst_rd_state", rd_state, 0);
    chk("arst_rd_action", rd_action, 0);
    repeat (2) tick();
    rst = 1;
    repeat (20) tick();
    chk("arst_no_upd_after", upd_cnt, 1);
    chk("arst_idle_busy", busy, 0);

    // Full run, start on the first edge after reset release.
    rst = 0; start = 0;
    repeat (2) tick();
    clear_mem();
    env_mode = 1; env_rew = 4'd1;
    env_dly = 0; upd_dly = 2; upd_cnt = 0; upd_viol = 0;
    rst = 1; start = 1;
    tick();
    start = 0;
    chk("run_first_start_busy", busy, 1);
    n = 0;
    while (!run_done && n < 2000) begin tick(); n++; end
    chk("run_done", run_done, 1);
    chk("run_busy", busy, 0);
    chk("run_episode", episode, 3);
    chk("run_upd_pulses", upd_cnt, 6);
    chk("run_hold_viol", upd_viol, 0);
    pulse_start();
    chk("restart_run_done", run_done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_episode", episode, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/q_step_ctrl.md
Q_STEP_CTRL -- requirements
Module: q_step_ctrl

Interface
REQ-001 SHALL have parameters: N_STATES=37 (maze states); N_ACT=4 (actions); START_STATE=0 (episode start); GOAL_STATE=36 (terminal state); EPS_THRESH=26 (8-bit explore threshold, about 0.1); MAX_STEPS=255 (step cap per episode); N_EPISODES=100 (training episodes per run).
REQ-002 SHALL have ports: clk in 1 (single clock, all logic on posedge); rst in 1 (asynchronous, active-low reset).
REQ-003 SHALL have ports: start in 1 (pulse, begin a training run); busy out 1 (run in progress); run_done out 1 (level, run finished).
REQ-004 SHALL have ports: rd_state out 6, rd_action out 2 (Q-table read address); rd_data in 32 (signed Q16.16, valid 1 cycle after address).
REQ-005 SHALL have ports: env_req out 1, env_state out 6, env_action out 2 (request to maze environment); env_ack in 1, env_next in 6, env_reward in 4 (environment response).
REQ-006 SHALL have ports: maze_state out 6, action out 2, max_Q out 32, reward out 4 (operands to Q-update unit); upd_go out 1 (1-cycle pulse); upd_done in 1 (update complete).
REQ-007 SHALL have ports: episode out 8 (completed episodes); steps out 8 (steps in current episode).

Function
REQ-008 SHALL implement FSM states IDLE, RD_CUR, SELECT, ENV, RD_NXT, UPDATE, ADVANCE, DONE.
REQ-009 IDLE -> RD_CUR on start=1; maze_state <= START_STATE, episode <= 0, steps <= 0; start ignored in all other states.
REQ-010 RD_CUR SHALL issue reads for actions 0..3 of maze_state on consecutive cycles and track signed argmax; tie resolves to lowest action index; duration exactly 5 cycles.
REQ-011 SELECT (1 cycle): LFSR byte < EPS_THRESH -> action <= LFSR[9:8]; else action <= argmax.
REQ-012 ENV SHALL hold env_req=1 with stable env_state/env_action until env_ack=1; on ack, latch env_next and env_reward, deassert env_req in the next cycle, go to RD_NXT; no timeout.
REQ-013 RD_NXT SHALL read 4 Q values of env_next (5 cycles) and latch the signed maximum into max_Q; if env_next==GOAL_STATE, max_Q <= 0 (terminal).
REQ-014 UPDATE SHALL pulse upd_go for exactly 1 cycle with maze_state/action/max_Q/reward stable, then hold them until upd_done=1; upd_done seen in the same cycle as upd_go SHALL be accepted.
REQ-015 ADVANCE (1 cycle): steps += 1; if env_next==GOAL_STATE or steps==MAX_STEPS-1, then episode += 1, steps <= 0, maze_state <= START_STATE; else maze_state <= env_next.
REQ-016 After ADVANCE: episode==N_EPISODES -> DONE; else -> RD_CUR.
REQ-017 DONE SHALL hold run_done=1, busy=0; start=1 SHALL clear run_done and restart as in REQ-009.
REQ-018 busy SHALL be 1 in every state except IDLE and DONE.
REQ-019 LFSR SHALL be a 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1, stepping every cycle; seed 0 is unreachable.
REQ-020 Out-of-range env_next (>= N_STATES) SHALL be treated as GOAL_STATE (episode ends, max_Q=0).
REQ-021 Q comparisons SHALL be signed 32-bit; no saturation needed.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE, including mid-handshake: env_req=0, upd_go=0, busy=0, run_done=0, episode=0, steps=0, maze_state=START_STATE, action=0, max_Q=0, reward=0, rd_state=0, rd_action=0, LFSR=16'hACE1.
REQ-023 After rst release, the first start is accepted on the first posedge.

Structure
REQ-024 Package q_pkg SHALL hold N_STATES, N_ACT, state_t (6-bit), action_t (2-bit), qval_t (signed 32-bit), and the FSM enum.
REQ-025 Sub-module q_argmax4 SHALL implement the sequential 4-entry signed max/argmax tracker, instanced once and shared by RD_CUR and RD_NXT.

Verification
REQ-026 Greedy pick: EPS_THRESH=0, Q[0]={-5,7,7,3} -> action=1 (tie broken to lowest index), env_req asserted 6 cycles after start.
REQ-027 Terminal step: env_next=36, reward=10 -> upd_go with max_Q=0, reward=10; then episode=1, maze_state=0.
REQ-028 Handshake: env_ack delayed 20 cycles -> env_req held high, env_action stable, exactly one upd_go.
REQ-029 Step cap: environment never reaches goal -> episode increments after 255 updates, steps returns to 0.
REQ-030 Reset mid-UPDATE: rst low while waiting for upd_done -> all outputs at reset values immediately; no upd_go after release until a new start.
REQ-031 Full run: N_EPISODES=3, goal reached in 2 steps each -> 6 upd_go pulses, run_done=1, busy=0, episode=3.
